// File: rtl/cube_arbiter.sv
// cube_arbiter
// Shares one pipelined cube core among N_REQ requesters. Each requester hands
// over a XW-bit operand with valid/ready, the arbiter picks one per cycle in
// round-robin order, registers the operand into the core, and follows the
// operation through the core with an index tag pipeline so the result lands
// in that requester's result register, held until acknowledged.
//
// Ports:
//   clk, rst_n          - clock (rising edge), synchronous active-low reset
//   req_valid[N_REQ]    - requester i presents an operand
//   req_x[N_REQ*XW]     - operands, requester i at [i*XW +: XW]
//   req_ready[N_REQ]    - one-hot grant (combinational)
//   core_x[XW]          - registered operand to the cube core
//   core_y[YW]          - cube core result, LAT clocks after core_x
//   rsp_valid[N_REQ]    - result for requester i is held
//   rsp_y[N_REQ*YW]     - results, requester i at [i*YW +: YW]
//   rsp_ack[N_REQ]      - requester i consumes its result
//   busy                - some operation is still travelling through the core
//
// Handshake semantics: a transfer on requester i happens on the rising edge
// where req_valid[i] & req_ready[i] are both high. req_ready never depends on
// req_x, a requester may drop req_valid before it is granted, and req_x must
// stay stable while req_valid is high and no transfer has happened yet. On the
// result side, rsp_valid[i] & rsp_ack[i] at a rising edge consumes the result;
// rsp_ack[i] with rsp_valid[i] low has no effect.

module cube_arbiter #(
  parameter int N_REQ = 4,
  parameter int XW    = 7,
  parameter int YW    = 21,
  parameter int LAT   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*XW-1:0] req_x,
  output logic [N_REQ-1:0]   req_ready,
  output logic [XW-1:0]      core_x,
  input  logic [YW-1:0]      core_y,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [N_REQ*YW-1:0] rsp_y,
  input  logic [N_REQ-1:0]   rsp_ack,
  output logic               busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int NT = LAT + 1;

  logic [IW-1:0]          last_q, last_d;
  logic [XW-1:0]          core_x_q, core_x_d;
  logic [N_REQ-1:0]       pend_q, pend_d;
  logic [N_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [N_REQ*YW-1:0]    rsp_y_q, rsp_y_d;
  logic [NT-1:0]          tag_vld_q, tag_vld_d;
  logic [NT-1:0][IW-1:0]  tag_idx_q, tag_idx_d;

  logic [N_REQ-1:0]       elig;
  logic [N_REQ-1:0]       gnt;
  logic [IW-1:0]          gnt_idx;
  logic                   hs;
  logic                   cap;
  logic [IW-1:0]          cap_idx;

  // Round-robin search starting just after the last granted index. Using the
  // registered rsp_valid in eligibility means an ack and a re-grant of the
  // same requester can never share a cycle.
  always_comb begin
    int            cand;
    logic [IW-1:0] cidx;
    logic          found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    cidx    = '0;
    elig    = req_valid & ~pend_q & ~rsp_valid_q;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = int'(last_q) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cidx = IW'(cand);
      if (!found && elig[cidx]) begin
        found     = 1'b1;
        gnt[cidx] = 1'b1;
        gnt_idx   = cidx;
      end
    end
  end

  assign hs      = |(req_valid & gnt);
  assign cap     = tag_vld_q[NT-1];
  assign cap_idx = tag_idx_q[NT-1];

  always_comb begin
    core_x_d    = core_x_q;
    last_d      = last_q;
    pend_d      = pend_q;
    rsp_valid_d = rsp_valid_q & ~rsp_ack;
    rsp_y_d     = rsp_y_q;
    tag_vld_d   = '0;
    tag_idx_d   = '0;

    // Tag pipeline mirrors the core latency: entry 0 lines up with core_x,
    // the last entry lines up with the matching core_y.
    tag_vld_d[0] = hs;
    tag_idx_d[0] = gnt_idx;
    for (int i = 1; i < NT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end

    // Eligibility guarantees the captured requester has no unacked result,
    // and a granted requester is never the one being captured.
    if (cap) begin
      pend_d[cap_idx]              = 1'b0;
      rsp_valid_d[cap_idx]         = 1'b1;
      rsp_y_d[cap_idx*YW +: YW]    = core_y;
    end

    if (hs) begin
      pend_d[gnt_idx] = 1'b1;
      core_x_d        = req_x[gnt_idx*XW +: XW];
      last_d          = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_x_q    <= '0;
      last_q      <= IW'(N_REQ - 1);
      pend_q      <= '0;
      rsp_valid_q <= '0;
      rsp_y_q     <= '0;
      tag_vld_q   <= '0;
      tag_idx_q   <= '0;
    end else begin
      core_x_q    <= core_x_d;
      last_q      <= last_d;
      pend_q      <= pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
    end
  end

  assign req_ready = gnt;
  assign core_x    = core_x_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign busy      = |tag_vld_q;

endmodule

// File: tb/tb_cube_arbiter.sv
// tb_cube_arbiter
// Directed bench for cube_arbiter with a behavioural cube core of latency LAT.
// Requesters are fed from per-requester operand lists; every observed
// handshake pushes the hand-expected cube, index and arrival cycle into a
// scoreboard queue, and a monitor pops and compares whenever a result appears.

module tb_cube_arbiter;

  localparam int N_REQ = 4;
  localparam int XW    = 7;
  localparam int YW    = 21;
  localparam int LAT   = 3;

  typedef struct packed {
    logic [3:0]    idx;
    logic [YW-1:0] y;
    logic [31:0]   due;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n = 1'b0;
  logic [N_REQ-1:0]     req_valid = '0;
  logic [N_REQ*XW-1:0]  req_x = '0;
  logic [N_REQ-1:0]     req_ready;
  logic [XW-1:0]        core_x;
  logic [YW-1:0]        core_y;
  logic [N_REQ-1:0]     rsp_valid;
  logic [N_REQ*YW-1:0]  rsp_y;
  logic [N_REQ-1:0]     rsp_ack;
  logic                 busy;

  logic [N_REQ-1:0]     auto_ack = '0;
  logic [N_REQ-1:0]     man_ack = '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cube_arbiter #(.N_REQ(N_REQ), .XW(XW), .YW(YW), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .core_x    (core_x),
    .core_y    (core_y),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .rsp_ack   (rsp_ack),
    .busy      (busy)
  );

  function automatic logic [YW-1:0] cube(input logic [XW-1:0] x);
    logic [YW-1:0] v;
    v = YW'(x);
    return v * v * v;
  endfunction

  // Behavioural core: core_y follows core_x by LAT clocks.
  logic [YW-1:0] core_pipe [LAT];
  always @(posedge clk) begin
    core_pipe[0] <= cube(core_x);
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_y = core_pipe[LAT-1];

  // Immediate ack for requesters in auto mode, plus manual pulses.
  assign rsp_ack = (rsp_valid & auto_ack) | man_ack;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];
  int   gnt_exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  logic [XW-1:0] sup_x [N_REQ][16];
  int sup_n  [N_REQ] = '{default: 0};
  int sup_rd [N_REQ] = '{default: 0};
  logic [N_REQ-1:0] hs_seen = '0;

  task automatic push_op(input int i, input logic [XW-1:0] x);
    sup_x[i][sup_n[i]] = x;
    sup_n[i] = sup_n[i] + 1;
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (!rst_n) sup_rd[i] = 0;
      else if (hs_seen[i]) sup_rd[i] = sup_rd[i] + 1;
      req_valid[i] = rst_n && (sup_rd[i] < sup_n[i]);
      req_x[i*XW +: XW] = (sup_rd[i] < sup_n[i]) ? sup_x[i][sup_rd[i]] : '0;
    end
  end

  // ---------------- monitor ----------------
  logic [N_REQ-1:0]    prev_valid = '0;
  logic [N_REQ-1:0]    prev_ack = '0;
  logic [N_REQ*YW-1:0] prev_y = '0;

  always @(negedge clk) begin : monitor
    logic busy_exp;
    exp_t e;
    logic [N_REQ-1:0] rise;
    if (!rst_n) begin
      hs_seen = '0;
    end else begin
      busy_exp = 1'b0;
      foreach (exp_q[k])
        if (cyc >= int'(exp_q[k].due) - LAT - 1 && cyc < int'(exp_q[k].due)) busy_exp = 1'b1;
      check("busy", busy, busy_exp);
      check("ready_onehot", ($countones(req_ready) <= 1), 1);
      check("ready_vs_held_rsp", req_ready & rsp_valid, 0);

      rise = rsp_valid & ~prev_valid;
      for (int i = 0; i < N_REQ; i++) begin
        if (rise[i]) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: requester %0d value %0d with nothing expected (cycle %0d)",
                     i, rsp_y[i*YW +: YW], cyc);
          end else begin
            e = exp_q.pop_front();
            check("rsp_idx", i, e.idx);
            check("rsp_y", rsp_y[i*YW +: YW], e.y);
            check("rsp_cycle", cyc, e.due);
          end
        end
        if (rsp_valid[i] && prev_valid[i] && !prev_ack[i])
          check("rsp_hold", rsp_y[i*YW +: YW], prev_y[i*YW +: YW]);
      end

      hs_seen = req_valid & req_ready;
      for (int i = 0; i < N_REQ; i++) begin
        if (hs_seen[i]) begin
          if (gnt_exp_q.size() > 0) check("grant_order", i, gnt_exp_q.pop_front());
          exp_q.push_back('{idx: 4'(i), y: cube(req_x[i*XW +: XW]), due: 32'(cyc + LAT + 2)});
        end
      end
    end
    prev_valid = rsp_valid;
    prev_ack   = rsp_ack;
    prev_y     = rsp_y;
  end

  // ---------------- helper tasks ----------------
  task automatic wait_idle(input string name, input logic [N_REQ-1:0] mask);
    int t;
    logic done;
    t = 0;
    done = 1'b0;
    while (!done && t < 500) begin
      @(negedge clk);
      t++;
      done = (exp_q.size() == 0) && !busy;
      for (int i = 0; i < N_REQ; i++)
        if (mask[i] && (sup_rd[i] < sup_n[i] || req_valid[i])) done = 1'b0;
    end
    check({name, "_idle"}, done, 1);
    repeat (2) @(negedge clk);
  endtask

  // Called at a negedge; holds reset across exactly one rising edge.
  task automatic do_reset(input string name);
    rst_n = 1'b0;
    exp_q.delete();
    gnt_exp_q.delete();
    for (int i = 0; i < N_REQ; i++) sup_n[i] = 0;
    @(negedge clk);
    check({name, "_core_x"}, core_x, 0);
    check({name, "_rsp_valid"}, rsp_valid, 0);
    check({name, "_rsp_y"}, rsp_y, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_req_ready"}, req_ready, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    repeat (2) @(negedge clk);
    do_reset("rst0");

    // 1: single operation, x=3 -> 27
    auto_ack = '1;
    @(negedge clk);
    push_op(0, 7'd3);
    wait_idle("t1", '1);
    check("t1_core_x", core_x, 3);
    check("t1_rsp_y0", rsp_y[0*YW +: YW], 27);

    // 2: all four at once after reset -> grants 0,1,2,3
    do_reset("rst2");
    gnt_exp_q = '{0, 1, 2, 3};
    push_op(0, 7'd1);
    push_op(1, 7'd2);
    push_op(2, 7'd3);
    push_op(3, 7'd4);
    wait_idle("t2", '1);
    check("t2_grants_done", gnt_exp_q.size(), 0);
    check("t2_core_x", core_x, 4);
    check("t2_rsp_y3", rsp_y[3*YW +: YW], 64);

    // 3: requester 0 holds an unacked result and is blocked until it acks
    auto_ack = 4'b1110;
    push_op(0, 7'd3);
    wait_idle("t3a", '1);
    check("t3_held_valid", rsp_valid[0], 1);
    gnt_exp_q = '{1, 2, 3, 0};
    push_op(0, 7'd5);
    push_op(1, 7'd10);
    push_op(2, 7'd11);
    push_op(3, 7'd12);
    wait_idle("t3b", 4'b1110);
    check("t3_blocked_ready0", req_ready[0], 0);
    check("t3_held_y0", rsp_y[0*YW +: YW], 27);
    man_ack = 4'b0001;
    check("t3_ready0_ack_cycle", req_ready[0], 0);
    @(negedge clk);
    man_ack = '0;
    check("t3_ready0_after_ack", req_ready[0], 1);
    auto_ack = '1;
    wait_idle("t3c", '1);
    check("t3_grants_done", gnt_exp_q.size(), 0);
    check("t3_rsp_y0", rsp_y[0*YW +: YW], 125);

    // 4: boundary operands held unacked for 10 cycles
    auto_ack = 4'b1001;
    push_op(1, 7'd127);
    push_op(2, 7'd0);
    wait_idle("t4", '1);
    for (int k = 0; k < 10; k++) begin
      check("t4_y127", rsp_y[1*YW +: YW], 2048383);
      check("t4_y0", rsp_y[2*YW +: YW], 0);
      check("t4_valid", rsp_valid[2:1], 2'b11);
      @(negedge clk);
    end
    auto_ack = '1;
    wait_idle("t4b", '1);

    // 5: reset with three operations in flight
    push_op(1, 7'd2);
    push_op(2, 7'd3);
    push_op(3, 7'd4);
    repeat (4) @(negedge clk);
    check("t5_inflight", exp_q.size(), 3);
    check("t5_busy", busy, 1);
    do_reset("t5_rst");
    for (int k = 0; k < 2 * LAT; k++) begin
      @(negedge clk);
      check("t5_no_rsp", rsp_valid, 0);
    end
    gnt_exp_q = '{0, 3};
    push_op(3, 7'd6);
    push_op(0, 7'd7);
    wait_idle("t5", '1);
    check("t5_grants_done", gnt_exp_q.size(), 0);

    // 6: requesters 0 and 2 alternate strictly over 20 operations
    for (int k = 0; k < 10; k++) begin
      push_op(0, 7'(10 + k));
      push_op(2, 7'(100 + k));
      gnt_exp_q.push_back(0);
      gnt_exp_q.push_back(2);
    end
    wait_idle("t6", '1);
    check("t6_grants_done", gnt_exp_q.size(), 0);
    check("t6_rsp_y2", rsp_y[2*YW +: YW], 1295029);

    check("final_scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cube_arbiter.md
# cube_arbiter

Shares one pipelined `cube_by_core` unit among `N_REQ` requesters in the Snell's-law datapath. Each requester presents a 7-bit operand with a valid/ready handshake. The arbiter grants one requester per cycle in round-robin order, drives the core operand register, and tracks in-flight operations with an index tag pipeline matched to the core latency. It captures each 21-bit cube into a per-requester result register, which is held until that requester acknowledges it.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `XW`, 7: operand width; must match the core input.
- `YW`, 21: result width; must match the core output (`3*XW`).
- `LAT`, 3: core latency in clocks from a `core_x` change to the matching `core_y` (0 = combinational).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `req_valid`, in, `N_REQ`: requester i has an operand.
- `req_x`, in, `N_REQ*XW`: operands; requester i at `[i*XW +: XW]`.
- `req_ready`, out, `N_REQ`: one-hot grant. A handshake occurs when `req_valid[i] & req_ready[i]`.
- `core_x`, out, `XW`: registered operand to the cube core.
- `core_y`, in, `YW`: cube core result.
- `rsp_valid`, out, `N_REQ`: result for requester i is held.
- `rsp_y`, out, `N_REQ*YW`: results; requester i at `[i*YW +: YW]`.
- `rsp_ack`, in, `N_REQ`: requester i consumes its result.
- `busy`, out, 1: at least one operation is in flight in the tag pipeline.

## Operation
- Per-requester `pend[i]` is set on handshake and cleared on capture. Requester i is eligible when `req_valid[i] & ~pend[i] & ~rsp_valid[i]`, so it has at most one outstanding operation.
- Arbitration:
  - `req_ready` is combinational from the eligibility vector and the registered pointer `last`.
  - The grant goes to the first eligible index searching `last+1, last+2, ...` with wrap-around modulo `N_REQ`.
  - `last` is updated to the granted index only on a handshake.
  - At most one `req_ready` bit is high. All are 0 when nothing is eligible.
- On a handshake for requester g:
  - `core_x <= req_x[g]`.
  - The tag pipeline entry 0 is loaded with `{valid=1, idx=g}`.
- Without a handshake, `core_x` holds its value and entry 0 loads `valid=0`.
- The tag pipeline has `LAT+1` entries and shifts every cycle. `busy` is the OR of all valid bits.
- When the last entry is valid with idx k:
  - `rsp_y[k] <= core_y`, `rsp_valid[k] <= 1`, `pend[k] <= 0`.
- `rsp_valid[i]` stays high and `rsp_y[i]` stays stable until `rsp_ack[i]` is sampled high. `rsp_valid[i]` then clears on that edge.
- `rsp_ack[i]` while `rsp_valid[i]=0` is ignored.
- Ack and re-grant of the same requester cannot occur in the same cycle. Eligibility uses the registered `rsp_valid`, so the earliest re-grant is the cycle after the ack.
- A capture for requester k cannot collide with an unacked result for k, because eligibility prevents it.
- Arithmetic is done entirely by the core. The arbiter does no truncation. `127^3 = 2048383` fits in `YW`.

## Timing
- Reset, sampled on the rising edge while `rst_n=0`:
  - `core_x=0`, `rsp_valid=0`, `rsp_y=0`, `pend=0`.
  - All tag valid bits are 0, so `busy=0`.
  - `last=N_REQ-1`, so requester 0 has first priority.
  - Derived from these registers, `req_ready=0` while `rst_n=0` only if `req_valid=0`. Benches drive `req_valid=0` during reset.
- Reset in the middle of operation discards all in-flight operations. No `rsp_valid` results from operations issued before reset.
- Latency: a handshake in cycle t gives `rsp_valid[g]=1` starting in cycle `t+LAT+2`. Breakdown:
  - `core_x` updates at the end of cycle t.
  - The core needs `LAT` cycles.
  - The capture register adds one cycle.
- Throughput: one handshake per cycle across requesters. A single requester can complete at most one operation per `LAT+3` cycles when it acks immediately.
- `req_x[i]` must be stable while `req_valid[i]=1` and the handshake has not yet occurred. A requester may deassert valid before it is granted, with no effect.

## Test plan
1. Reset, then requester 0 holds `req_valid=1`, `x=3` -> handshake in cycle t. `core_x=3` from t+1. `rsp_valid[0]=1` and `rsp_y[0]=27` at `t+LAT+2`. `busy` is high from t+1 through the capture edge.
2. All four requesters are valid in the same cycle with x=1,2,3,4 -> grants 0,1,2,3 on consecutive cycles. Results 1, 8, 27, 64 each appear `LAT+2` cycles after their own grant.
3. Requester 0 leaves result 27 unacked and re-requests with x=5 -> `req_ready[0]` stays 0 while requesters 1..3 are served. `rsp_ack[0]` is pulsed in cycle a -> `req_ready[0]` can first be high in cycle a+1. The new result is 125.
4. Boundary operands: x=127 -> 2048383; x=0 -> 0. `rsp_y` is held stable for 10 unacked cycles.
5. Issue three operations, then assert `rst_n=0` for one cycle before any capture -> all outputs return to their reset values, no `rsp_valid` is seen for 2*LAT cycles after reset, and the next request goes to requester 0.
6. Requesters 0 and 2 request continuously and ack each result immediately -> grants strictly alternate 0, 2, 0, 2, with no starvation across 20 operations.
